// File: rtl/soc_ram_byte_logger.sv
// soc_ram_byte_logger
//
// Logs an 8-bit stream into a circular window of the on-chip RAM through
// its second port. Bytes are packed little-endian into 32-bit words and
// written at BASE + offset. Partial words are written by a CSR flush or,
// when the optional feature is built in, by an idle timeout.
//
// Optional feature macro: SOC_RAM_LOGGER_TIMEOUT_EN
//   defined     -> 16-bit idle counter auto-flushes a partial word after
//                  TIMEOUT idle cycles
//   not defined -> partial words are written only by CSR FLUSH
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   in_data/in_valid    stream byte and its valid
//   in_ready            ENABLE & ~FULL
//   csr_*               Avalon-MM CSR slave (read latency 1)
//                         0 CTRL   bit0 ENABLE, bit1 WRAP, bit2 FLUSH, bit3 CLEAR
//                         1 BASE   first word address
//                         2 LAST   last word offset (window = LAST+1 words)
//                         3 STATUS offset, bit16 FULL, bit17 WRAPPED (W1C),
//                                  bits19:18 pending byte count
//   ram_*               RAM port 2 write interface (registered, no wait state)
//   ram_clken           constant 1
module soc_ram_byte_logger #(
  parameter int ADDR_W  = 13,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic              ram_clken
);

  // Control / configuration registers
  logic              enable_q;
  logic              wrap_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] last_q;

  // Window state
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic              full_q, full_d;
  logic              wrapped_q, wrapped_d;

  // Pack register
  logic [1:0]        pend_q, pend_d;
  logic [31:0]       pack_data_q, pack_data_d;
  logic [3:0]        pack_be_q, pack_be_d;

  // Registered RAM and CSR outputs
  logic              ram_write_q;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [3:0]        ram_be_q, ram_be_d;
  logic [31:0]       ram_data_q, ram_data_d;
  logic [31:0]       csr_rdata_q, csr_rdata_d;

  // Decoded strobes
  logic              accept;
  logic              ctrl_wr;
  logic              status_wr;
  logic              flush_csr;
  logic              clear;
  logic              flush_req;
  logic              timeout_hit;
  logic              word_done;
  logic              emit;
  logic              wrap_event;
  logic [ADDR_W-1:0] offset_adv;
  logic [31:0]       byte_data;
  logic [3:0]        byte_be;
  logic [31:0]       merged_data;
  logic [3:0]        merged_be;

  logic unused_wdata;
  assign unused_wdata = ^csr_writedata;

  assign in_ready  = enable_q & ~full_q;
  assign accept    = in_valid & in_ready;
  assign ctrl_wr   = csr_write && (csr_address == 2'd0);
  assign status_wr = csr_write && (csr_address == 2'd3);
  assign flush_csr = ctrl_wr & csr_writedata[2];
  assign clear     = ctrl_wr & csr_writedata[3];
  assign flush_req = flush_csr | timeout_hit;

`ifdef SOC_RAM_LOGGER_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  assign timeout_hit = (tmo_q == 16'(TIMEOUT)) && (pend_q != 2'd0) && !accept;

  always_comb begin
    tmo_d = '0;
    if (!(clear || emit || accept) && (pend_q != 2'd0))
      tmo_d = tmo_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    // Lane selected by the current pending count
    byte_data   = {24'd0, in_data} << {pend_q, 3'b000};
    byte_be     = 4'b0001 << pend_q;
    merged_data = pack_data_q | (accept ? byte_data : '0);
    merged_be   = pack_be_q   | (accept ? byte_be   : '0);

    word_done = accept && (pend_q == 2'd3);
    // A byte accepted on the flush edge is part of the flushed word
    emit = !clear && (word_done || (flush_req && (accept || (pend_q != 2'd0))));

    pend_d      = pend_q;
    pack_data_d = pack_data_q;
    pack_be_d   = pack_be_q;
    if (clear || emit) begin
      pend_d      = '0;
      pack_data_d = '0;
      pack_be_d   = '0;
    end else if (accept) begin
      pend_d      = pend_q + 2'd1;
      pack_data_d = merged_data;
      pack_be_d   = merged_be;
    end

    // Offset advances on the edge that ends a RAM write cycle
    wrap_event = ram_write_q && (offset_q == last_q);
    offset_adv = offset_q;
    if (ram_write_q)
      offset_adv = wrap_event ? '0 : offset_q + ADDR_W'(1);

    offset_d  = clear ? '0 : offset_adv;
    full_d    = clear ? 1'b0 : (full_q | (wrap_event & ~wrap_q));
    wrapped_d = wrapped_q;
    if (status_wr && csr_writedata[17])
      wrapped_d = 1'b0;
    if (wrap_event && wrap_q)
      wrapped_d = 1'b1;
    if (clear)
      wrapped_d = 1'b0;

    // A new word uses the already-advanced offset so a write issuing in
    // this cycle and one registered now never share an address.
    ram_address_d = '0;
    ram_be_d      = '0;
    ram_data_d    = '0;
    if (emit) begin
      ram_address_d = base_q + offset_adv;
      ram_be_d      = merged_be;
      ram_data_d    = merged_data;
    end

    csr_rdata_d = '0;
    case (csr_address)
      2'd0: csr_rdata_d[1:0]        = {wrap_q, enable_q};
      2'd1: csr_rdata_d[ADDR_W-1:0] = base_q;
      2'd2: csr_rdata_d[ADDR_W-1:0] = last_q;
      default: begin
        csr_rdata_d[ADDR_W-1:0] = offset_q;
        csr_rdata_d[16]         = full_q;
        csr_rdata_d[17]         = wrapped_q;
        csr_rdata_d[19:18]      = pend_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q      <= 1'b0;
      wrap_q        <= 1'b0;
      base_q        <= '0;
      last_q        <= '1;
      offset_q      <= '0;
      full_q        <= 1'b0;
      wrapped_q     <= 1'b0;
      pend_q        <= '0;
      pack_data_q   <= '0;
      pack_be_q     <= '0;
      ram_write_q   <= 1'b0;
      ram_address_q <= '0;
      ram_be_q      <= '0;
      ram_data_q    <= '0;
      csr_rdata_q   <= '0;
    end else begin
      if (ctrl_wr) begin
        enable_q <= csr_writedata[0];
        wrap_q   <= csr_writedata[1];
      end
      if (csr_write && (csr_address == 2'd1)) base_q <= csr_writedata[ADDR_W-1:0];
      if (csr_write && (csr_address == 2'd2)) last_q <= csr_writedata[ADDR_W-1:0];
      offset_q      <= offset_d;
      full_q        <= full_d;
      wrapped_q     <= wrapped_d;
      pend_q        <= pend_d;
      pack_data_q   <= pack_data_d;
      pack_be_q     <= pack_be_d;
      ram_write_q   <= emit;
      ram_address_q <= ram_address_d;
      ram_be_q      <= ram_be_d;
      ram_data_q    <= ram_data_d;
      if (csr_read) csr_rdata_q <= csr_rdata_d;
    end
  end

  assign ram_write      = ram_write_q;
  assign ram_chipselect = ram_write_q;
  assign ram_address    = ram_address_q;
  assign ram_byteenable = ram_be_q;
  assign ram_writedata  = ram_data_q;
  assign ram_clken      = 1'b1;
  assign csr_readdata   = csr_rdata_q;

endmodule

// File: doc/soc_ram_byte_logger.md
# soc_ram_byte_logger

Byte-stream logger that sits directly upstream of the SoC on-chip RAM's second port (s2). It accepts 8-bit samples from a streaming source (GPS/NMEA UART receiver, anemometer decoder), packs them little-endian into 32-bit words, and writes them into a CSR-programmed circular window of the 8192×32 RAM. The Nios II reads the logged data back through port s1. A small Avalon-MM CSR slave provides control and status.

## Interface
Parameters:
- ADDR_W, 13, RAM word-address width; matches the 8192-word RAM.
- TIMEOUT, 1024, idle cycles with a partial word pending before auto-flush; range 1..65535.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  byte present.
- in_ready  out  1  byte accepted when in_valid & in_ready at the rising edge.
- csr_address  in  2  CSR word select.
- csr_read  in  1  CSR read strobe.
- csr_write  in  1  CSR write strobe.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data; registered, read latency 1.
- ram_address  out  ADDR_W  to RAM address2.
- ram_byteenable  out  4  to RAM byteenable2.
- ram_chipselect  out  1  to RAM chipselect2.
- ram_write  out  1  to RAM write2.
- ram_writedata  out  32  to RAM writedata2.
- ram_clken  out  1  to RAM clken2; constant 1.

## Operation
CSR map:
- 0 CTRL: bit0 ENABLE, bit1 WRAP (1 = circular, 0 = stop when full), bit2 FLUSH (write-1 pulse, reads 0), bit3 CLEAR (write-1 pulse, reads 0).
- 1 BASE: [ADDR_W-1:0] first word address.
- 2 LAST: [ADDR_W-1:0] last word offset; window size is LAST+1 words.
- 3 STATUS (read): [ADDR_W-1:0] next write offset, bit16 FULL, bit17 WRAPPED (sticky), bits18-19 pending byte count. Writing 1 to bit17 clears WRAPPED.

Packing:
- in_ready = ENABLE & ~FULL.
- The k-th pending byte (k = 0..3) goes to lane k (bits 8k+7:8k); the lane mask is accumulated.
- On the 4th byte, the word moves to the output register and the pack register empties in the same edge. Back-to-back acceptance continues without a bubble.

Flush:
- Triggered by CSR FLUSH, or by the idle timeout (see Configuration), while 1–3 bytes are pending.
- Emits one write with ram_byteenable equal to the filled lanes. Unfilled lanes of ram_writedata are 0.
- The next byte starts a new word at lane 0.
- FLUSH with 0 pending bytes is a no-op.

Address:
- ram_address = BASE + offset, modulo 2^ADDR_W.
- Offset increments after each RAM write.
- After a write at offset == LAST: offset → 0. If WRAP=1, WRAPPED is set. If WRAP=0, FULL is set and in_ready drops.

CLEAR:
- Resets offset to 0 and clears FULL, WRAPPED and pending bytes (pending data is discarded).
- Does not alter ENABLE, WRAP, BASE or LAST.

Disabling ENABLE keeps pending bytes; they are written only by a flush.

Reset values:
- in_ready 0, csr_readdata 0, ram_write 0, ram_chipselect 0, ram_byteenable 0, ram_writedata 0, ram_address 0, ram_clken 1.
- Registers: CTRL 0, BASE 0, LAST 8191, offset 0, FULL 0, WRAPPED 0, pending 0, timeout counter 0.

## Timing
- Byte completing a word is accepted at edge N. ram_write, ram_chipselect, ram_address, ram_byteenable and ram_writedata are asserted for exactly the one cycle following edge N. Offset updates at edge N+1.
- CSR FLUSH written at edge N → partial write in the cycle after N. If a byte is accepted at the same edge N, it is included in the flushed word; if that byte completes the word, a single full write occurs.
- The RAM has no wait state: every ram_write completes in its cycle.
- CLEAR at the same edge as a byte acceptance: CLEAR wins and the byte is discarded. A RAM write already registered for the following cycle still issues, at its already-registered address.
- CSR read: csr_readdata is valid one cycle after csr_read. It reflects state after the preceding edge.
- Reset asserted mid-word: all pending data is lost and outputs take their reset values at the next edge.

## Configuration
- SOC_RAM_LOGGER_TIMEOUT_EN defined: a 16-bit idle counter runs while 1–3 bytes are pending and no byte is accepted. Any acceptance reloads it to 0. Reaching TIMEOUT triggers a flush identical to a CSR FLUSH.
- Not defined: no counter is implemented; partial words are written only by CSR FLUSH.

## Test plan
- BASE=0x100, LAST=3, WRAP=0, ENABLE; stream bytes 0x01..0x10 → writes 0x04030201@0x100, 0x08070605@0x101, 0x0C0B0A09@0x102, 0x100F0E0D@0x103; then FULL=1, in_ready=0, STATUS offset 0.
- WRAP=1, LAST=1, 12 bytes → addresses BASE, BASE+1, BASE; WRAPPED=1; writing STATUS bit17=1 clears it.
- Send 0xAA, 0xBB, then CSR FLUSH → one write of 0x0000BBAA with byteenable 0011; next byte lands in lane 0 at the next address.
- With SOC_RAM_LOGGER_TIMEOUT_EN and TIMEOUT=8: send one byte 0x5A, then idle → write 0x0000005A, byteenable 0001, issued 8 cycles after acceptance plus 1. Without the macro → no write.
- Send 3 bytes then CLEAR → no RAM write, offset 0, pending 0; synchronous reset mid-stream → all outputs at reset values after one edge, LAST reads 8191.
